pkt_prio_queue: RTL and testbench

- Parametrised successor to the single-queue packet priorer: a multi-class packet queue with NUM_PRIO independent FIFOs of DEPTH entries each, all sharing one enqueue port and one dequeue port.
- A configurable arbiter (strict priority or round-robin) chooses which class is presented at the output.
- Adds per-class occupancy reporting and a saturating drop counter for rejected enqueues.
- Sits between header parsing and the egress scheduler.

---
 rtl/pkt_prio_queue.sv | 165 ++++++++++++++++
 tb/tb_pkt_prio_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_prio_queue.sv
// Multi-class packet queue: NUM_PRIO show-ahead FIFOs behind one enqueue and one dequeue port,
// with a strict-priority or round-robin output arbiter, per-class occupancy and a drop counter.
module pkt_prio_queue #(
    parameter int DWIDTH   = 64,
    parameter int NUM_PRIO = 4,
    parameter int DEPTH    = 8,
    parameter int MODE     = 0,
    localparam int PW      = (NUM_PRIO > 2) ? $clog2(NUM_PRIO) : 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_en,
    input  logic [PW-1:0]          in_prior,
    input  logic [DWIDTH-1:0]      in_data,
    output logic                   in_valid,
    input  logic                   out_deque_en,
    output logic                   out_valid,
    output logic [DWIDTH-1:0]      out_data,
    output logic [PW-1:0]          out_prior,
    output logic [NUM_PRIO*CW-1:0] occupancy,
    output logic [15:0]            drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]        rst_sync_r;
    logic              rst_n_s;
    logic [DWIDTH-1:0] mem_r [NUM_PRIO][DEPTH];
    logic [AW-1:0]     rd_ptr_r [NUM_PRIO];
    logic [AW-1:0]     wr_ptr_r [NUM_PRIO];
    logic [CW-1:0]     cnt_r [NUM_PRIO];
    logic [PW-1:0]     rr_ptr_r;
    logic [PW-1:0]     rr_next_s;
    logic [15:0]       drop_cnt_r;
    logic [NUM_PRIO-1:0] nonempty_s;
    logic [NUM_PRIO-1:0] push_s;
    logic [NUM_PRIO-1:0] pop_s;
    logic [PW-1:0]     sel_s;
    logic              in_valid_s;
    logic              any_s;
    logic              accept_s;
    logic              pop_any_s;
    int                rr_idx_s;
    int                rr_inc_s;

    // Reset synchroniser: assertion is immediate, release waits two clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    // Per-class status and enqueue readiness from registered counts.
    always_comb begin
        in_valid_s = 1'b0;
        nonempty_s = {NUM_PRIO{1'b0}};
        for (int i = 0; i < NUM_PRIO; i++) begin
            nonempty_s[i] = (cnt_r[i] != {CW{1'b0}});
            if (in_prior == PW'(i)) begin
                in_valid_s = (cnt_r[i] != CW'(DEPTH));
            end else begin
                in_valid_s = in_valid_s;
            end
        end
    end

    // Arbiter: strict keeps the last (highest) non-empty index; round-robin keeps the smallest offset from rr_ptr.
    always_comb begin
        sel_s    = {PW{1'b0}};
        rr_idx_s = 0;
        if (MODE == 0) begin
            for (int i = 0; i < NUM_PRIO; i++) begin
                if (nonempty_s[i]) begin
                    sel_s = PW'(i);
                end else begin
                    sel_s = sel_s;
                end
            end
        end else begin
            for (int k = NUM_PRIO - 1; k >= 0; k--) begin
                rr_idx_s = int'(rr_ptr_r) + k;
                if (rr_idx_s >= NUM_PRIO) begin
                    rr_idx_s = rr_idx_s - NUM_PRIO;
                end else begin
                    rr_idx_s = rr_idx_s;
                end
                if (nonempty_s[rr_idx_s]) begin
                    sel_s = PW'(rr_idx_s);
                end else begin
                    sel_s = sel_s;
                end
            end
        end
    end

    // Handshake decode and round-robin successor.
    always_comb begin
        any_s     = |nonempty_s;
        accept_s  = in_en & in_valid_s;
        pop_any_s = out_deque_en & any_s;
        push_s    = {NUM_PRIO{1'b0}};
        pop_s     = {NUM_PRIO{1'b0}};
        for (int i = 0; i < NUM_PRIO; i++) begin
            push_s[i] = accept_s  & (in_prior == PW'(i));
            pop_s[i]  = pop_any_s & (sel_s == PW'(i));
        end
        rr_inc_s = int'(sel_s) + 1;
        if (rr_inc_s >= NUM_PRIO) begin
            rr_next_s = {PW{1'b0}};
        end else begin
            rr_next_s = PW'(rr_inc_s);
        end
    end

    // FIFO pointers and counts per class.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < NUM_PRIO; i++) begin
                rd_ptr_r[i] <= {AW{1'b0}};
                wr_ptr_r[i] <= {AW{1'b0}};
                cnt_r[i]    <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_PRIO; i++) begin
                if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
                if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
                case ({push_s[i], pop_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Round-robin pointer and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rr_ptr_r   <= {PW{1'b0}};
            drop_cnt_r <= 16'h0000;
        end else begin
            if (pop_any_s) rr_ptr_r <= rr_next_s;
            if (in_en && !in_valid_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    // Payload storage; contents need no reset since out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (accept_s) mem_r[in_prior][wr_ptr_r[in_prior]] <= in_data;
    end

    for (genvar g = 0; g < NUM_PRIO; g++) begin : g_occ
        assign occupancy[g*CW +: CW] = cnt_r[g];
    end

    assign in_valid  = in_valid_s;
    assign out_valid = any_s;
    assign out_prior = sel_s;
    assign out_data  = any_s ? mem_r[sel_s][rd_ptr_r[sel_s]] : {DWIDTH{1'b0}};
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pkt_prio_queue.sv
// Scoreboard bench for pkt_prio_queue: one strict-priority and one round-robin instance share stimulus;
// the monitor checks popped entries of the instance currently under test against hand-computed sequences.
module tb_pkt_prio_queue;
    localparam int DW = 64;
    localparam int NP = 4;
    localparam int DP = 4;
    localparam int CW = 3;

    typedef struct packed {
        logic [1:0]    p;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_en = 1'b0;
    logic [1:0] in_prior = 2'd0;
    logic [DW-1:0] in_data = '0;
    logic out_deque_en = 1'b0;

    logic iv0, iv1, v0, v1;
    logic [DW-1:0] d0, d1;
    logic [1:0] p0, p1;
    logic [NP*CW-1:0] occ0, occ1;
    logic [15:0] dc0, dc1;

    logic act = 1'b0;
    logic m_iv, m_valid;
    logic [DW-1:0] m_data;
    logic [1:0] m_prior;
    logic [NP*CW-1:0] m_occ;
    logic [15:0] m_drop;

    int n_checks = 0;
    int n_pass = 0;
    exp_t sb[$];

    pkt_prio_queue #(.DWIDTH(DW), .NUM_PRIO(NP), .DEPTH(DP), .MODE(0)) u_strict (
        .clk(clk), .rst(rst), .in_en(in_en), .in_prior(in_prior), .in_data(in_data),
        .in_valid(iv0), .out_deque_en(out_deque_en), .out_valid(v0), .out_data(d0),
        .out_prior(p0), .occupancy(occ0), .drop_cnt(dc0));

    pkt_prio_queue #(.DWIDTH(DW), .NUM_PRIO(NP), .DEPTH(DP), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_en(in_en), .in_prior(in_prior), .in_data(in_data),
        .in_valid(iv1), .out_deque_en(out_deque_en), .out_valid(v1), .out_data(d1),
        .out_prior(p1), .occupancy(occ1), .drop_cnt(dc1));

    assign m_iv    = act ? iv1  : iv0;
    assign m_valid = act ? v1   : v0;
    assign m_data  = act ? d1   : d0;
    assign m_prior = act ? p1   : p0;
    assign m_occ   = act ? occ1 : occ0;
    assign m_drop  = act ? dc1  : dc0;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && m_valid && out_deque_en) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pop: got prior %0d data %0d, expected no output", m_prior, m_data);
            end else begin
                e = sb.pop_front();
                if (m_prior === e.p && m_data === e.d) n_pass++;
                else $display("FAIL pop: got prior %0d data %0d, expected prior %0d data %0d",
                              m_prior, m_data, e.p, e.d);
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input int p, input logic [DW-1:0] d);
        in_en    = 1'b1;
        in_prior = p[1:0];
        in_data  = d;
        tick();
        in_en    = 1'b0;
    endtask

    task automatic expect_out(input int p, input logic [DW-1:0] d);
        exp_t e;
        e.p = p[1:0];
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        out_deque_en = 1'b1;
        for (int i = 0; i < budget && sb.size() > 0; i++) tick();
        out_deque_en = 1'b0;
        chk("drain_complete", DW'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        // Reset values
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_out_valid", DW'(m_valid), 64'd0);
        chk("rst_out_data", m_data, 64'd0);
        chk("rst_occupancy", DW'(m_occ), 64'd0);
        chk("rst_drop_cnt", DW'(m_drop), 64'd0);
        for (int p = 0; p < NP; p++) begin
            in_prior = p[1:0];
            #1;
            chk($sformatf("rst_in_valid_%0d", p), DW'(m_iv), 64'd1);
        end

        // Strict priority
        act = 1'b0;
        enq(1, 64'd114514);
        chk("sp_latency_valid", DW'(m_valid), 64'd1);
        chk("sp_latency_data", m_data, 64'd114514);
        enq(3, 64'd7);
        enq(1, 64'd9);
        expect_out(3, 64'd7);
        expect_out(1, 64'd114514);
        expect_out(1, 64'd9);
        drain(10);
        chk("sp_empty_after", DW'(m_valid), 64'd0);
        chk("sp_empty_data", m_data, 64'd0);

        // Round-robin
        do_reset();
        act = 1'b1;
        enq(0, 64'd0);  enq(0, 64'd1);
        enq(2, 64'd20); enq(2, 64'd21);
        enq(3, 64'd30); enq(3, 64'd31);
        expect_out(0, 64'd0);  expect_out(2, 64'd20); expect_out(3, 64'd30);
        expect_out(0, 64'd1);  expect_out(2, 64'd21); expect_out(3, 64'd31);
        drain(12);
        chk("rr_empty_after", DW'(m_valid), 64'd0);

        // Full and drop
        do_reset();
        act = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_prior = 2'd2;
            #1;
            chk($sformatf("full_in_valid_%0d", k), DW'(m_iv), (k < 4) ? 64'd1 : 64'd0);
            enq(2, DW'(100 + k));
        end
        chk("full_drop_cnt", DW'(m_drop), 64'd2);
        chk("full_occ_c2", DW'(m_occ[2*CW +: CW]), 64'd4);
        for (int k = 0; k < 4; k++) expect_out(2, DW'(100 + k));
        drain(10);

        // Simultaneous enqueue/dequeue on class 0
        do_reset();
        enq(0, 64'd500);
        enq(0, 64'd501);
        expect_out(0, 64'd500);
        expect_out(0, 64'd501);
        for (int k = 0; k < 5; k++) expect_out(0, DW'(510 + k));
        for (int k = 0; k < 5; k++) begin
            in_en        = 1'b1;
            in_prior     = 2'd0;
            in_data      = DW'(510 + k);
            out_deque_en = 1'b1;
            tick();
            chk($sformatf("simul_count_%0d", k), DW'(m_occ[0 +: CW]), 64'd2);
        end
        in_en        = 1'b0;
        out_deque_en = 1'b0;
        drain(10);
        chk("simul_drop_cnt", DW'(m_drop), 64'd0);

        // Asynchronous reset mid-operation
        do_reset();
        enq(1, 64'd600);
        enq(1, 64'd601);
        enq(1, 64'd602);
        chk("async_pre_occ", DW'(m_occ[1*CW +: CW]), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_out_valid", DW'(m_valid), 64'd0);
        chk("async_occupancy", DW'(m_occ), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        enq(2, 64'd700);
        chk("async_new_valid", DW'(m_valid), 64'd1);
        chk("async_new_prior", DW'(m_prior), 64'd2);
        chk("async_new_data", m_data, 64'd700);
        expect_out(2, 64'd700);
        drain(10);

        chk("scoreboard_leftover", DW'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
